piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//  Parametrised parallel-in/serial-out serializer with valid/ready input handshake.
//  Shifts one bit per i_bit_tick strobe, with selectable bit order and idle line level.
//  A one-word holding buffer allows back-to-back frames with no idle gap.
//  Sits between a byte source (FIFO/CPU) and a bit-rate tick generator; this is the core of UART/SPI TX.
// PARAMETERS
//  WIDTH       8  bits per word; must be >= 2
//  MSB_FIRST   0  0: shift out bit 0 first; 1: shift out bit WIDTH-1 first
//  IDLE_LEVEL  1  o_serial value whenever no word is being shifted
// PORTS
//  i_clk          in   1      system clock; all state updates on the rising edge
//  i_reset_n      in   1      asynchronous, active-low reset
//  i_valid        in   1      i_data holds a word to send
//  o_ready        out  1      block can accept a word; the transfer happens when i_valid & o_ready
//  i_data         in   WIDTH  parallel word
//  i_bit_tick     in   1      one-cycle strobe that ends the current bit period
//  o_serial       out  1      serial data line
//  o_busy         out  1      a word is being shifted (state SHIFT)
//  o_done         out  1      one-cycle pulse when the last bit period of a word ends
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE, holding buffer empty, shifter and bit count cleared.
//   - o_serial=IDLE_LEVEL, o_ready=1, o_busy=0, o_done=0.
//  o_ready = !hold_full. It is registered state and never depends combinationally on i_valid.
//  States: IDLE, SHIFT. bit_cnt width is $clog2(WIDTH) and counts 0..WIDTH-1.
//  IDLE:
//   - On accept, i_data loads directly into the shifter at that edge.
//   - Next state is SHIFT with bit_cnt=0.
//   - i_bit_tick is ignored.
//  SHIFT:
//   - o_serial = shifter[0] if MSB_FIRST=0, else shifter[WIDTH-1]. It is a registered bit, valid from the load edge.
//   - The first bit's period starts at the load edge; only ticks after that edge count.
//   - Tick with bit_cnt < WIDTH-1: shift by 1 toward the output end, fill with 0, bit_cnt+1.
//   - Tick with bit_cnt = WIDTH-1 (frame end): assert o_done the next cycle (1 cycle wide).
//     - If hold is full: load the shifter from hold, clear hold, bit_cnt=0, stay in SHIFT. There is no idle cycle.
//     - Else: go to IDLE with o_serial=IDLE_LEVEL.
//   - Accept while in SHIFT writes the holding buffer; o_ready drops the next cycle.
//  Simultaneous events:
//   - Frame-end tick + accept with hold empty: the accepted word goes straight into the shifter (seamless), hold stays empty.
//   - Frame-end tick + accept is impossible with hold full, because o_ready=0.
//   - Accept in the same cycle hold is drained: not permitted. o_ready is still 0 that cycle and rises the next cycle.
//  i_valid without o_ready: no effect; the source must hold i_data stable.
//  Reset mid-frame: the frame is abandoned, the held word is lost, and o_serial returns to IDLE_LEVEL immediately.
//  Throughput: 1 word per WIDTH ticks; latency from accept to first bit on o_serial is 1 clock.
// STRUCTURE
//  Shared header serial_defs.vh holds:
//   - state encodings (S_IDLE=1'b0, S_SHIFT=1'b1)
//   - the CLOG2 helper, reused by the future receive side
//  One sub-module, piso_hold_buf: a 1-entry valid/ready skid register (data + full flag).
//  The FSM, shifter and bit counter stay in the top module.
// TESTING
//  1. Reset: assert i_reset_n=0 mid-frame -> o_serial=1, o_busy=0, o_ready=1 with no clock edge needed.
//  2. WIDTH=8, MSB_FIRST=0, word 8'hA5, tick every 4 clk:
//     - o_serial sequence 1,0,1,0,0,1,0,1.
//     - o_done pulses once after the 8th tick.
//     - o_serial=1 afterwards.
//  3. MSB_FIRST=1, word 8'hA5 -> sequence 1,0,1,0,0,1,0,1 (MSB first).
//     Then word 8'h01 -> 0,0,0,0,0,0,0,1.
//  4. Back-to-back: send 8'hFF, then 8'h00 while the first is shifting:
//     - o_ready=0 until the frame boundary.
//     - o_serial is 1 for 8 ticks, then 0 for 8 ticks, with no IDLE cycle.
//     - o_done pulses twice.
//  5. Tick asserted on the accept cycle in IDLE -> ignored; 8 further ticks are required to finish the word.
//  6. Random valid/tick stalls, 200 words, scoreboard -> every accepted word emitted exactly once, in order, with no extra o_done.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serializer datapath: FSM state encoding and a
// ceiling-log2 helper that the receive side will reuse.
package piso_serializer_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    // Number of bits needed to index 0..value-1 (value >= 2).
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding register that parks the next word while the shifter is busy.
// The full flag doubles as the inverted ready seen by the word source.
module piso_hold_buf
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic             o_full,
    output logic [WIDTH-1:0] o_rd_data
);

    logic             full_q;
    logic             full_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (i_rd_en) begin
            full_d = 1'b0;
        end
        // A write is only ever issued while empty, so it cannot collide with a drain.
        if (i_wr_en) begin
            full_d = 1'b1;
            data_d = i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign o_full    = full_q;
    assign o_rd_data = data_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: one bit per i_bit_tick, selectable bit order,
// with a one-word holding buffer so consecutive frames run without an idle gap.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b0,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_bit_tick,
    output logic             o_serial,
    output logic             o_busy,
    output logic             o_done
);

    localparam int              CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_d;
    logic             serial_q;
    logic             serial_d;
    logic             done_q;
    logic             done_d;

    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic             hold_wr;
    logic             hold_rd;
    logic             accept;
    logic             frame_end;
    logic [WIDTH-1:0] shift_step;

    assign accept    = i_valid & ~hold_full;
    assign frame_end = (state_q == S_SHIFT) && i_bit_tick && (bit_cnt_q == LAST_BIT);

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shift_step = {shift_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign shift_step = {1'b0, shift_q[WIDTH-1:1]};
        end
    endgenerate

    piso_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold_buf (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_wr_en   (hold_wr),
        .i_wr_data (i_data),
        .i_rd_en   (hold_rd),
        .o_full    (hold_full),
        .o_rd_data (hold_data)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        hold_wr   = 1'b0;
        hold_rd   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shift_d   = i_data;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (frame_end) begin
                    done_d    = 1'b1;
                    bit_cnt_d = '0;
                    if (hold_full) begin
                        shift_d = hold_data;
                        hold_rd = 1'b1;
                    end else if (accept) begin
                        // Word arriving exactly at the boundary bypasses the holding buffer.
                        shift_d = i_data;
                    end else begin
                        shift_d = '0;
                        state_d = S_IDLE;
                    end
                end else begin
                    if (i_bit_tick) begin
                        shift_d   = shift_step;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                    hold_wr = accept;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The line bit is registered from the next shifter value so it is glitch-free.
        if (state_d == S_SHIFT) begin
            serial_d = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
        end else begin
            serial_d = IDLE_LEVEL;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            serial_q  <= IDLE_LEVEL;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            serial_q  <= serial_d;
            done_q    <= done_d;
        end
    end

    assign o_ready  = ~hold_full;
    assign o_serial = serial_q;
    assign o_busy   = (state_q == S_SHIFT);
    assign o_done   = done_q;

endmodule
